rram_wl_sequencer: RTL and testbench

Operation sequencer that sits directly upstream of the 5-to-32 wordline decoder in the RRAM macro. It accepts one array operation at a time (READ, SET, RESET, FORM) on a valid/ready handshake and drives the decoder's enable and 5-bit row address. It also drives the bitline/sourceline bias mode and the sense-amp strobe with break-before-make phase timing, then returns a one-cycle response.

---
 rtl/rram_wl_sequencer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_rram_wl_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rram_wl_sequencer.sv
// Wordline/bias/sense sequencer feeding the RRAM 5-to-32 wordline decoder.
// Define RRAM_SEQ_VERIFY_EN to add write-verify reads with bounded retries.
module rram_wl_sequencer #(
  parameter int SETUP_CYC   = 2,
  parameter int READ_CYC    = 4,
  parameter int SET_CYC     = 8,
  parameter int RESET_CYC   = 8,
  parameter int FORM_CYC    = 32,
  parameter int RECOVER_CYC = 2,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [4:0] req_addr,
  output logic       dec_en,
  output logic [4:0] dec_din,
  output logic [1:0] drv_mode,
  output logic       sa_strobe,
  input  logic       sa_out,
  output logic       rsp_valid,
  output logic       rsp_data,
  output logic       rsp_fail
);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] DRV_FLOAT = 2'b00;
  localparam logic [1:0] DRV_READ  = 2'b01;
  localparam logic [1:0] DRV_SET   = 2'b10;
  localparam logic [1:0] DRV_RESET = 2'b11;

  // Phase counter counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [7:0] cyc_load(input int c);
    if (c <= 1) cyc_load = 8'd0;
    else        cyc_load = 8'(c - 1);
  endfunction

  localparam logic [7:0] SETUP_LD   = cyc_load(SETUP_CYC);
  localparam logic [7:0] READ_LD    = cyc_load(READ_CYC);
  localparam logic [7:0] SET_LD     = cyc_load(SET_CYC);
  localparam logic [7:0] RESET_LD   = cyc_load(RESET_CYC);
  localparam logic [7:0] FORM_LD    = cyc_load(FORM_CYC);
  localparam logic [7:0] RECOVER_LD = cyc_load(RECOVER_CYC);

  generate
    if (SETUP_CYC > 255 || READ_CYC > 255 || SET_CYC > 255 || RESET_CYC > 255 ||
        FORM_CYC > 255 || RECOVER_CYC > 255 || MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_cfg
      $error("rram_wl_sequencer: illegal timing or retry parameter");
    end
  endgenerate

  function automatic logic [7:0] pulse_load(input logic [1:0] op);
    case (op)
      OP_READ:  pulse_load = READ_LD;
      OP_SET:   pulse_load = SET_LD;
      OP_RESET: pulse_load = RESET_LD;
      default:  pulse_load = FORM_LD;
    endcase
  endfunction

  function automatic logic [1:0] op_bias(input logic [1:0] op);
    case (op)
      OP_READ:  op_bias = DRV_READ;
      OP_RESET: op_bias = DRV_RESET;
      default:  op_bias = DRV_SET;
    endcase
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_PULSE    = 3'd2,
    ST_RECOVER  = 3'd3,
    ST_DONE     = 3'd4
`ifdef RRAM_SEQ_VERIFY_EN
    ,
    ST_VSETUP   = 3'd5,
    ST_VPULSE   = 3'd6,
    ST_VRECOVER = 3'd7
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [4:0] addr_q, addr_d;
  logic       req_ready_q, req_ready_d;
  logic       dec_en_q, dec_en_d;
  logic [1:0] drv_mode_q, drv_mode_d;
  logic       sa_strobe_q, sa_strobe_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_data_q, rsp_data_d;
`ifdef RRAM_SEQ_VERIFY_EN
  logic [3:0] retry_q, retry_d;
  logic       rsp_fail_q, rsp_fail_d;
`endif

  // Next-state, phase counter and latched request
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    addr_d     = addr_q;
    rsp_data_d = sa_strobe_q ? sa_out : rsp_data_q;
`ifdef RRAM_SEQ_VERIFY_EN
    retry_d    = retry_q;
    rsp_fail_d = rsp_fail_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d    = ST_SETUP;
          cnt_d      = SETUP_LD;
          op_d       = req_op;
          addr_d     = req_addr;
          rsp_data_d = 1'b0;
`ifdef RRAM_SEQ_VERIFY_EN
          retry_d    = 4'd0;
          rsp_fail_d = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_PULSE;
          cnt_d   = pulse_load(op_q);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_RECOVER;
          cnt_d   = RECOVER_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 8'd0) begin
`ifdef RRAM_SEQ_VERIFY_EN
          if (op_q != OP_READ) begin
            state_d = ST_VSETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = ST_DONE;
          end
`else
          state_d = ST_DONE;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
`ifdef RRAM_SEQ_VERIFY_EN
      ST_VSETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_VPULSE;
          cnt_d   = READ_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_VPULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_VRECOVER;
          cnt_d   = RECOVER_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_VRECOVER: begin
        // RESET should leave the cell high-resistance (0); SET/FORM low-resistance (1)
        if (cnt_q == 8'd0) begin
          if (rsp_data_q == (op_q != OP_RESET)) begin
            state_d    = ST_DONE;
            rsp_fail_d = 1'b0;
          end else if (retry_q < 4'(MAX_RETRY)) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
            retry_d = retry_q + 4'd1;
          end else begin
            state_d    = ST_DONE;
            rsp_fail_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    dec_en_d    = 1'b0;
    drv_mode_d  = DRV_FLOAT;
    sa_strobe_d = 1'b0;
    case (state_d)
      ST_SETUP: drv_mode_d = op_bias(op_d);
      ST_PULSE: begin
        dec_en_d    = 1'b1;
        drv_mode_d  = op_bias(op_d);
        sa_strobe_d = (op_d == OP_READ) && (cnt_d == 8'd0);
      end
`ifdef RRAM_SEQ_VERIFY_EN
      ST_VSETUP: drv_mode_d = DRV_READ;
      ST_VPULSE: begin
        dec_en_d    = 1'b1;
        drv_mode_d  = DRV_READ;
        sa_strobe_d = (cnt_d == 8'd0);
      end
`endif
      default: drv_mode_d = DRV_FLOAT;
    endcase
  end

  // State and output registers; reset drops the wordline immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      op_q        <= 2'b00;
      addr_q      <= 5'd0;
      req_ready_q <= 1'b1;
      dec_en_q    <= 1'b0;
      drv_mode_q  <= DRV_FLOAT;
      sa_strobe_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 1'b0;
`ifdef RRAM_SEQ_VERIFY_EN
      retry_q     <= 4'd0;
      rsp_fail_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      dec_en_q    <= dec_en_d;
      drv_mode_q  <= drv_mode_d;
      sa_strobe_q <= sa_strobe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef RRAM_SEQ_VERIFY_EN
      retry_q     <= retry_d;
      rsp_fail_q  <= rsp_fail_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign dec_en    = dec_en_q;
  assign dec_din   = addr_q;
  assign drv_mode  = drv_mode_q;
  assign sa_strobe = sa_strobe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
`ifdef RRAM_SEQ_VERIFY_EN
  assign rsp_fail  = rsp_fail_q;
`else
  assign rsp_fail  = 1'b0;
`endif

endmodule

// File: tb/tb_rram_wl_sequencer.sv
// Scoreboard bench for rram_wl_sequencer: directed requests push expectations,
// a negedge monitor checks phase timing, invariants and each response.
`timescale 1ns/1ps
module tb_rram_wl_sequencer;
`ifdef RRAM_SEQ_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam logic [1:0] OP_READ = 2'b00, OP_SET = 2'b01, OP_RESET = 2'b10, OP_FORM = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [4:0] req_addr = 5'd0;
  logic       sa_out = 1'b0;
  logic       req_ready, dec_en, sa_strobe, rsp_valid, rsp_data, rsp_fail;
  logic [4:0] dec_din;
  logic [1:0] drv_mode;

  always #5 clk = ~clk;

  rram_wl_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .dec_en(dec_en), .dec_din(dec_din),
    .drv_mode(drv_mode), .sa_strobe(sa_strobe), .sa_out(sa_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fail(rsp_fail)
  );

  typedef struct {
    logic [4:0] addr;
    logic [1:0] mode;
    int         lat;
    int         data;
    int         fail;
    int         pulse_cyc;
    int         vfy_cyc;
    int         strobes;
    int         first_en;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] a, input logic [1:0] m, input int lat, input int d,
                              input int f, input int p, input int v, input int s);
    exp_t e;
    e.addr = a; e.mode = m; e.lat = lat; e.data = d; e.fail = f;
    e.pulse_cyc = p; e.vfy_cyc = v; e.strobes = s; e.first_en = 3;
    return e;
  endfunction

  // Sense-amp model: value for the n-th strobe is sa_before until sa_flip strobes have passed
  int   strobe_total = 0;
  int   sa_flip = 0;
  logic sa_before = 1'b0, sa_after = 1'b0;
  always @(negedge clk) begin
    sa_out = (strobe_total >= sa_flip) ? sa_after : sa_before;
    if (sa_strobe) strobe_total++;
  end

  task automatic set_sa(input logic v);
    sa_before = v; sa_after = v; sa_flip = 0;
  endtask

  // Monitor
  bit         in_op = 1'b0, ready_pending = 1'b0;
  int         op_cyc, pulse_cnt, vfy_cnt, st_cnt, first_en;
  logic       prev_en = 1'b0;
  logic [4:0] prev_din;
  logic [1:0] prev_mode;
  exp_t       e_mon;

  always @(negedge clk) begin
    if (rst) begin
      in_op = 1'b0; prev_en = 1'b0; ready_pending = 1'b0;
    end else begin
      if (in_op) op_cyc++;
      if (ready_pending) begin
        chk("ready_after_done", req_ready, 1);
        ready_pending = 1'b0;
      end
      if (dec_en) begin
        if (!in_op || exp_q.size() == 0) begin
          chk("dec_en_outside_op", 1, 0);
        end else begin
          chk("dec_din_in_pulse", dec_din, exp_q[0].addr);
          if (drv_mode == exp_q[0].mode) pulse_cnt++;
          else if (drv_mode == 2'b01) vfy_cnt++;
          else chk("drv_mode_in_pulse", drv_mode, exp_q[0].mode);
          if (first_en < 0) first_en = op_cyc;
        end
        if (prev_en) begin
          chk("din_stable_in_pulse", dec_din, prev_din);
          chk("mode_stable_in_pulse", drv_mode, prev_mode);
        end
      end
      if (sa_strobe) begin
        st_cnt++;
        chk("strobe_only_in_read_pulse", {dec_en, drv_mode}, 3'b101);
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e_mon = exp_q.pop_front();
          chk("latency", op_cyc, e_mon.lat);
          chk("rsp_data", rsp_data, e_mon.data);
          chk("rsp_fail", rsp_fail, e_mon.fail);
          chk("pulse_cycles", pulse_cnt, e_mon.pulse_cyc);
          chk("verify_cycles", vfy_cnt, e_mon.vfy_cyc);
          chk("strobe_count", st_cnt, e_mon.strobes);
          chk("first_wl_cycle", first_en, e_mon.first_en);
          chk("ready_in_done", req_ready, 0);
          ready_pending = 1'b1;
        end
        in_op = 1'b0;
      end
      if (req_valid && req_ready) begin
        in_op = 1'b1; op_cyc = 0; pulse_cnt = 0; vfy_cnt = 0; st_cnt = 0; first_en = -1;
      end
      prev_en = dec_en; prev_din = dec_din; prev_mode = drv_mode;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge
  task automatic send(input logic [1:0] op, input logic [4:0] addr, input exp_t e, input bit hold);
    int k = 0;
    while (!req_ready && k < 200) begin
      @(posedge clk); #1; k++;
    end
    chk("ready_wait_timeout", (k < 200) ? 1 : 0, 1);
    req_op = op; req_addr = addr; req_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1; k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    int last_acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dec_en", dec_en, 0);
    chk("rst_dec_din", dec_din, 0);
    chk("rst_drv_mode", drv_mode, 0);
    chk("rst_sa_strobe", sa_strobe, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_fail", rsp_fail, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);

    // READ at 0x13, cell reads low-resistance
    set_sa(1'b1);
    send(OP_READ, 5'h13, mk(5'h13, 2'b01, 9, 1, 0, 4, 0, 1), 1'b0);
    drain(60);

    // SET at 0x00 then RESET at 0x1F (sa chosen to pass verify in the verify build)
    set_sa(1'b1);
    send(OP_SET, 5'h00, mk(5'h00, 2'b10, VER ? 21 : 13, VER ? 1 : 0, 0, 8, VER ? 4 : 0, VER ? 1 : 0), 1'b0);
    send(OP_RESET, 5'h1F, mk(5'h1F, 2'b11, VER ? 21 : 13, 0, 0, 8, VER ? 4 : 0, VER ? 1 : 0), 1'b0);
    set_sa(1'b0);
    drain(100);

    // Full FORM at 0x15
    set_sa(1'b1);
    send(OP_FORM, 5'h15, mk(5'h15, 2'b10, VER ? 45 : 37, VER ? 1 : 0, 0, 32, VER ? 4 : 0, VER ? 1 : 0), 1'b0);
    drain(100);

    // Reset during the FORM pulse (cycle 10) aborts without a response
    send(OP_FORM, 5'h0C, mk(5'h0C, 2'b10, 0, 0, 0, 0, 0, 0), 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("wl_on_before_abort", dec_en, 1);
    chk("bias_before_abort", drv_mode, 2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_dec_en", dec_en, 0);
    chk("abort_drv_mode", drv_mode, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_abort_ready", req_ready, 1);
    chk("post_abort_dec_din", dec_din, 0);

    // READ after release, cell reads high-resistance
    set_sa(1'b0);
    send(OP_READ, 5'h0A, mk(5'h0A, 2'b01, 9, 0, 0, 4, 0, 1), 1'b0);
    drain(60);

    // Eight READs with req_valid held high throughout
    set_sa(1'b1);
    last_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send(OP_READ, 5'(i), mk(5'(i), 2'b01, 9, 1, 0, 4, 0, 1), 1'b1);
      if (i > 0) chk("accept_spacing", cyc - last_acc, 10);
      last_acc = cyc;
    end
    req_valid = 1'b0;
    drain(60);

`ifdef RRAM_SEQ_VERIFY_EN
    // SET failing the first two verify reads: three write attempts
    sa_before = 1'b0; sa_after = 1'b1; sa_flip = strobe_total + 2;
    send(OP_SET, 5'h07, mk(5'h07, 2'b10, 61, 1, 0, 24, 12, 3), 1'b0);
    drain(120);

    // RESET with sense stuck at 1: 1+MAX_RETRY attempts then failure
    set_sa(1'b1);
    send(OP_RESET, 5'h18, mk(5'h18, 2'b11, 81, 1, 1, 32, 16, 4), 1'b0);
    drain(150);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
